// File: rtl/mips_lsu_pkg.sv
// -----------------------------------------------------------------------------
// mips_lsu_pkg
// Shared types and helpers for the MIPS load/store bus bridge.
//   size_t         : access size encoding carried on req_size
//   IDLE/ACCESS/RESP : bridge FSM state codes
//   is_legal()     : alignment / reserved-size check
//   calc_byteenable() : lane enables for a given size and byte offset
// -----------------------------------------------------------------------------
package mips_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_t;

  // State codes kept as plain constants so the state register is a bare
  // vector that older tools and waveform scripts can decode.
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  // An access is legal when its size is defined and the address is
  // naturally aligned to that size.
  function automatic logic is_legal(input size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~addr_lo[0];
      SIZE_WORD: return (addr_lo == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

  // Lane k carries bits [8k+7:8k], i.e. byte offset k (little-endian).
  function automatic logic [3:0] calc_byteenable(input size_t size, input logic [1:0] addr_lo);
    case (size)
      SIZE_BYTE: return 4'b0001 << addr_lo;
      SIZE_HALF: return addr_lo[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_lane_align.sv
// -----------------------------------------------------------------------------
// mips_lsu_lane_align
// Purely combinational lane steering for the load/store bridge.
// Ports:
//   size        in  access size (registered request)
//   addr_lo     in  byte offset within the word
//   is_signed   in  sign-extend narrow loads when high
//   wdata_in    in  CPU store data (low byte / half used for narrow stores)
//   rdata_in    in  raw bus read data word
//   byteenable  out lane enables
//   wdata_out   out store data replicated across all lanes
//   rdata_out   out extracted and extended load data
// -----------------------------------------------------------------------------
module mips_lsu_lane_align
  import mips_lsu_pkg::*;
(
  input  size_t       size,
  input  logic [1:0]  addr_lo,
  input  logic        is_signed,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic [3:0]  byteenable,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [31:0] shifted;

  always_comb begin
    // NOTE: every output of this block gets a value before any branch, so no
    // path can leave one unassigned and infer a latch.
    byteenable = calc_byteenable(size, addr_lo);
    wdata_out  = wdata_in;
    rdata_out  = rdata_in;

    // Replicating the narrow datum on every lane lets the byte enables alone
    // select the target bytes at the slave.
    case (size)
      SIZE_BYTE: wdata_out = {4{wdata_in[7:0]}};
      SIZE_HALF: wdata_out = {2{wdata_in[15:0]}};
      default:   wdata_out = wdata_in;
    endcase

    // Accesses are aligned here, so shifting by the byte offset brings the
    // addressed byte or half down to bit 0 for both narrow sizes.
    shifted = rdata_in >> {addr_lo, 3'b000};
    case (size)
      SIZE_BYTE: rdata_out = {{24{is_signed & shifted[7]}},  shifted[7:0]};
      SIZE_HALF: rdata_out = {{16{is_signed & shifted[15]}}, shifted[15:0]};
      default:   rdata_out = rdata_in;
    endcase
  end

endmodule

// File: rtl/mips_lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// mips_lsu_bus_bridge
// Load/store unit between the CPU data port and a word-addressed bus with
// wait states. Registers one request, drives one bus transfer, stalls the CPU
// while the slave waits, then pulses a response with extended load data.
//
// Parameters:
//   TIMEOUT_CYCLES  waitrequest cycles tolerated before abort (>= 1); only
//                   used when the LSU_TIMEOUT_EN macro is defined.
// Configuration macro:
//   LSU_TIMEOUT_EN  adds a wait-state counter that aborts a stuck transfer
//                   with resp_error. Undefined: ACCESS waits indefinitely.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   req_valid/write/size/signed/address/writedata   CPU request
//   stall                      hold PC and request
//   resp_valid/readdata/error  one-cycle completion pulse and result
//   bus_address/read/write/byteenable/writedata     bus master outputs
//   bus_waitrequest, bus_readdata                   bus slave inputs
// -----------------------------------------------------------------------------
module mips_lsu_bus_bridge
  import mips_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_address,
  input  logic [31:0] req_writedata,
  output logic        stall,
  output logic        resp_valid,
  output logic [31:0] resp_readdata,
  output logic        resp_error,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be >= 1");
  end

  logic [1:0]  state;
  logic        r_write;
  logic        r_signed;
  size_t       r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        in_access;
  logic        accept;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_rdata;

`ifdef LSU_TIMEOUT_EN
  // Wide enough to hold TIMEOUT_CYCLES-1, never narrower than 8 bits.
  localparam int CNT_W = (TIMEOUT_CYCLES <= 256) ? 8 : $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] wait_cnt;
`endif

  assign in_access = (state == ACCESS);
  assign accept    = (state == IDLE) && req_valid;

  // Stall asserts in the accepting cycle itself so the CPU holds its PC
  // before the request has even been registered.
  assign stall      = (accept && !reset) || in_access;
  assign resp_valid = (state == RESP);

  // Bus fields are forced to 0 outside ACCESS so an idle bus carries no
  // stale lane enables or data.
  assign bus_read       = in_access && !r_write;
  assign bus_write      = in_access &&  r_write;
  assign bus_address    = in_access ? {r_addr[31:2], 2'b00} : 32'h0;
  assign bus_byteenable = in_access ? lane_be    : 4'b0000;
  assign bus_writedata  = in_access ? lane_wdata : 32'h0;

  mips_lsu_lane_align u_lane_align (
    .size       (r_size),
    .addr_lo    (r_addr[1:0]),
    .is_signed  (r_signed),
    .wdata_in   (r_wdata),
    .rdata_in   (bus_readdata),
    .byteenable (lane_be),
    .wdata_out  (lane_wdata),
    .rdata_out  (lane_rdata)
  );

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // here samples the pre-edge values, independent of statement order.
    if (reset) begin
      state         <= IDLE;
      r_write       <= 1'b0;
      r_signed      <= 1'b0;
      r_size        <= SIZE_BYTE;
      r_addr        <= 32'h0;
      r_wdata       <= 32'h0;
      resp_readdata <= 32'h0;
      resp_error    <= 1'b0;
`ifdef LSU_TIMEOUT_EN
      wait_cnt      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_signed <= req_signed;
            r_size   <= size_t'(req_size);
            r_addr   <= req_address;
            r_wdata  <= req_writedata;
            if (is_legal(size_t'(req_size), req_address[1:0])) begin
              state <= ACCESS;
`ifdef LSU_TIMEOUT_EN
              wait_cnt <= '0;
`endif
            end else begin
              // Illegal requests never reach the bus.
              state         <= RESP;
              resp_error    <= 1'b1;
              resp_readdata <= 32'h0;
            end
          end
        end

        ACCESS: begin
          if (!bus_waitrequest) begin
            state         <= RESP;
            resp_error    <= 1'b0;
            resp_readdata <= r_write ? 32'h0 : lane_rdata;
          end
`ifdef LSU_TIMEOUT_EN
          else if (wait_cnt == WAIT_LAST) begin
            // This is the TIMEOUT_CYCLES-th wait cycle: abandon the transfer.
            state         <= RESP;
            resp_error    <= 1'b1;
            resp_readdata <= 32'h0;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end

        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_lsu_bus_bridge.sv
// -----------------------------------------------------------------------------
// tb_mips_lsu_bus_bridge
// Self-checking bench for mips_lsu_bus_bridge. A transaction driver records
// what the bus and response ports did; each test compares those observations
// against a byte-level reference model of the access rules.
// -----------------------------------------------------------------------------
module tb_mips_lsu_bus_bridge;

  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_address, req_writedata;
  logic        stall, resp_valid, resp_error;
  logic [31:0] resp_readdata;
  logic [31:0] bus_address, bus_writedata, bus_readdata;
  logic        bus_read, bus_write, bus_waitrequest;
  logic [3:0]  bus_byteenable;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mips_lsu_bus_bridge #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk             (clk),
    .reset           (reset),
    .req_valid       (req_valid),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_address     (req_address),
    .req_writedata   (req_writedata),
    .stall           (stall),
    .resp_valid      (resp_valid),
    .resp_readdata   (resp_readdata),
    .resp_error      (resp_error),
    .bus_address     (bus_address),
    .bus_read        (bus_read),
    .bus_write       (bus_write),
    .bus_byteenable  (bus_byteenable),
    .bus_writedata   (bus_writedata),
    .bus_waitrequest (bus_waitrequest),
    .bus_readdata    (bus_readdata)
  );

  typedef struct {
    bit          legal;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    logic        stall0;
    logic        strobe0;
    int          nstrobe;
    logic        rd_s, wr_s;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    bit          held;
    bit          access_stall;
    bit          resp_seen;
    int          resp_cycle;
    logic [31:0] rdata;
    logic        err;
    bit          resp_clean;
    logic        after_valid;
    logic [31:0] hold_rdata;
  } obs_t;

  // Reference model: an access covers nbytes = 2**size consecutive bytes
  // starting at the byte offset; stores repeat the low nbytes on every lane.
  function automatic exp_t model(input logic wr, input logic [1:0] sz, input logic sg,
                                 input logic [31:0] addr, input logic [31:0] wd,
                                 input logic [31:0] rd);
    exp_t        e;
    int          nbytes, off;
    logic [31:0] mask, v;
    nbytes  = 1 << sz;
    off     = int'(addr[1:0]);
    e.legal = (sz != 2'd3) && ((off % nbytes) == 0);
    e.baddr = addr - 32'(off);
    e.be    = 4'b0;
    e.wdata = 32'h0;
    e.rdata = 32'h0;
    if (e.legal) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= off && k < off + nbytes) e.be[k] = 1'b1;
        e.wdata[8*k +: 8] = wd[8*(k % nbytes) +: 8];
      end
      if (!wr) begin
        if (nbytes == 4) e.rdata = rd;
        else begin
          mask = (32'd1 << (8 * nbytes)) - 32'd1;
          v    = (rd >> (8 * off)) & mask;
          if (sg && v[8*nbytes-1]) v = v | ~mask;
          e.rdata = v;
        end
      end
    end
    return e;
  endfunction

  // Drives one request from IDLE (caller is just after a rising edge) and
  // records the bus and response behaviour. waitrequest is held high for the
  // first `waits` strobe cycles, with junk on bus_readdata while it is high.
  task automatic run_txn(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rd, input int waits, output obs_t o);
    bit          first;
    logic [31:0] r;
    first          = 1'b1;
    o              = '{default: 0};
    o.held         = 1'b1;
    o.access_stall = 1'b1;
    req_valid = 1'b1; req_write = wr; req_size = sz; req_signed = sg;
    req_address = addr; req_writedata = wd;
    bus_waitrequest = 1'b1; bus_readdata = $urandom;
    @(negedge clk);
    o.stall0  = stall;
    o.strobe0 = bus_read | bus_write;
    @(posedge clk); #1;
    // Scramble the request: the bridge must use only what it registered.
    r = $urandom;
    req_valid = 1'b0; req_write = r[0]; req_size = r[2:1]; req_signed = r[3];
    req_address = $urandom; req_writedata = $urandom;
    for (int c = 1; c <= waits + 50; c++) begin
      bus_waitrequest = (o.nstrobe < waits);
      bus_readdata    = bus_waitrequest ? $urandom : rd;
      @(negedge clk);
      if (bus_read || bus_write) begin
        if (first) begin
          o.rd_s = bus_read; o.wr_s = bus_write; o.addr = bus_address;
          o.be = bus_byteenable; o.wdata = bus_writedata;
          first = 1'b0;
        end else if ({bus_read, bus_write, bus_address, bus_byteenable, bus_writedata}
                     !== {o.rd_s, o.wr_s, o.addr, o.be, o.wdata}) begin
          o.held = 1'b0;
        end
        if (stall !== 1'b1 || resp_valid !== 1'b0) o.access_stall = 1'b0;
        o.nstrobe++;
      end
      if (resp_valid === 1'b1) begin
        o.resp_seen  = 1'b1;
        o.resp_cycle = c;
        o.rdata      = resp_readdata;
        o.err        = resp_error;
        o.resp_clean = (stall === 1'b0) && (bus_read === 1'b0) && (bus_write === 1'b0);
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
    end
    bus_waitrequest = 1'b0;
    @(negedge clk);
    o.after_valid = resp_valid;
    o.hold_rdata  = resp_readdata;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2;
    req_address = 32'h1234_5678; req_writedata = 32'hFFFF_FFFF;
    bus_waitrequest = 1'b0; bus_readdata = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({stall, resp_valid, resp_error, bus_read, bus_write, resp_readdata,
         bus_address, bus_byteenable, bus_writedata} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: stall=%b rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h be=%b wd=%h, want all 0",
               stall, resp_valid, resp_error, bus_read, bus_write, resp_readdata,
               bus_address, bus_byteenable, bus_writedata);
    end
    @(posedge clk); #1;
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, bus_read, bus_write, resp_valid} !== 4'b0) begin
      bad++;
      $display("FAIL reset_idle: stall/rd/wr/rv=%b want 0000", {stall, bus_read, bus_write, resp_valid});
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_store();
    obs_t o;
    run_txn(1'b1, 2'd2, 1'b0, 32'h1004, 32'hDEAD_BEEF, 32'h0, 0, o);
    total++;
    if ({o.stall0, o.strobe0} !== 2'b10) begin
      bad++; $display("FAIL ws_cycle0: stall,strobe=%b want 10", {o.stall0, o.strobe0});
    end
    total++;
    if ({o.wr_s, o.rd_s, o.addr, o.be, o.wdata} !== {2'b10, 32'h1004, 4'b1111, 32'hDEAD_BEEF}) begin
      bad++; $display("FAIL ws_bus: wr=%b rd=%b addr=%h be=%b wd=%h want 1 0 00001004 1111 deadbeef",
                      o.wr_s, o.rd_s, o.addr, o.be, o.wdata);
    end
    total++;
    if (o.nstrobe != 1 || o.resp_cycle != 2 || o.err !== 1'b0 || o.rdata !== 32'h0 || !o.resp_clean) begin
      bad++; $display("FAIL ws_resp: strobes=%0d resp_cycle=%0d err=%b rdata=%h clean=%0d want 1 2 0 0 1",
                      o.nstrobe, o.resp_cycle, o.err, o.rdata, o.resp_clean);
    end
  endtask

  task automatic test_byte_load();
    obs_t o;
    run_txn(1'b0, 2'd0, 1'b1, 32'h2003, 32'h0, 32'h8011_2233, 3, o);
    total++;
    if (o.nstrobe != 4 || !o.held || !o.access_stall || o.rd_s !== 1'b1 || o.be !== 4'b1000 || o.addr !== 32'h2000) begin
      bad++; $display("FAIL bl_strobe: strobes=%0d held=%0d stall_ok=%0d rd=%b be=%b addr=%h want 4 1 1 1 1000 00002000",
                      o.nstrobe, o.held, o.access_stall, o.rd_s, o.be, o.addr);
    end
    total++;
    if (o.resp_cycle != 5 || o.rdata !== 32'hFFFF_FF80 || o.err !== 1'b0) begin
      bad++; $display("FAIL bl_signed: cycle=%0d rdata=%h err=%b want 5 ffffff80 0", o.resp_cycle, o.rdata, o.err);
    end
    total++;
    if (o.after_valid !== 1'b0 || o.hold_rdata !== 32'hFFFF_FF80) begin
      bad++; $display("FAIL bl_pulse_hold: next rv=%b rdata=%h want 0 ffffff80", o.after_valid, o.hold_rdata);
    end
    run_txn(1'b0, 2'd0, 1'b0, 32'h2003, 32'h0, 32'h8011_2233, 3, o);
    total++;
    if (o.rdata !== 32'h0000_0080 || o.resp_cycle != 5) begin
      bad++; $display("FAIL bl_unsigned: rdata=%h cycle=%0d want 00000080 5", o.rdata, o.resp_cycle);
    end
  endtask

  task automatic test_half();
    obs_t o;
    run_txn(1'b0, 2'd1, 1'b0, 32'h2002, 32'h0, 32'hABCD_1234, 0, o);
    total++;
    if (o.be !== 4'b1100 || o.rdata !== 32'h0000_ABCD) begin
      bad++; $display("FAIL half_load: be=%b rdata=%h want 1100 0000abcd", o.be, o.rdata);
    end
    run_txn(1'b1, 2'd1, 1'b0, 32'h10, 32'h0000_BEEF, 32'h0, 1, o);
    total++;
    if (o.be !== 4'b0011 || o.wdata !== 32'hBEEF_BEEF || o.wr_s !== 1'b1 || o.nstrobe != 2) begin
      bad++; $display("FAIL half_store: be=%b wd=%h wr=%b strobes=%0d want 0011 beefbeef 1 2",
                      o.be, o.wdata, o.wr_s, o.nstrobe);
    end
  endtask

  task automatic test_illegal();
    obs_t o;
    run_txn(1'b0, 2'd2, 1'b0, 32'h40, 32'h0, 32'h1234_5678, 0, o);
    total++;
    if (o.rdata !== 32'h1234_5678) begin
      bad++; $display("FAIL word_load: rdata=%h want 12345678", o.rdata);
    end
    run_txn(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 32'h5555_5555, 0, o);
    total++;
    if (o.stall0 !== 1'b1 || o.nstrobe != 0 || o.resp_cycle != 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
      bad++; $display("FAIL misaligned: stall0=%b strobes=%0d cycle=%0d err=%b rdata=%h want 1 0 1 1 0",
                      o.stall0, o.nstrobe, o.resp_cycle, o.err, o.rdata);
    end
    run_txn(1'b1, 2'd3, 1'b0, 32'h3000, 32'h7777_7777, 32'h0, 0, o);
    total++;
    if (o.nstrobe != 0 || o.resp_cycle != 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin
      bad++; $display("FAIL rsvd_size: strobes=%0d cycle=%0d err=%b rdata=%h want 0 1 1 0",
                      o.nstrobe, o.resp_cycle, o.err, o.rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    int   seen;
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_address = 32'h500; bus_waitrequest = 1'b1; bus_readdata = 32'h9999_9999;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    total++;
    if (bus_read !== 1'b1) begin
      bad++; $display("FAIL rst_mid_setup: bus_read=%b want 1", bus_read);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; bus_waitrequest = 1'b0;
    @(negedge clk);
    total++;
    if ({stall, resp_valid, resp_error, bus_read, bus_write, resp_readdata,
         bus_address, bus_byteenable, bus_writedata} !== '0) begin
      bad++; $display("FAIL rst_mid_outputs: stall=%b rv=%b rd=%b addr=%h be=%b rdata=%h want all 0",
                      stall, resp_valid, bus_read, bus_address, bus_byteenable, resp_readdata);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1 || bus_read === 1'b1) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL rst_mid_quiet: activity cycles=%0d want 0", seen);
    end
    @(posedge clk); #1;
    run_txn(1'b0, 2'd0, 1'b1, 32'h601, 32'h0, 32'h0000_7F00, 1, o);
    total++;
    if (!o.resp_seen || o.resp_cycle != 3 || o.rdata !== 32'h0000_007F || o.err !== 1'b0) begin
      bad++; $display("FAIL rst_mid_fresh: seen=%0d cycle=%0d rdata=%h err=%b want 1 3 0000007f 0",
                      o.resp_seen, o.resp_cycle, o.rdata, o.err);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] want [5];
    want = '{3'b010, 3'b011, 3'b100, 3'b010, 3'b011};
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_signed = 1'b0;
    req_address = 32'h80; bus_waitrequest = 1'b0; bus_readdata = 32'h1111_2222;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if ({resp_valid, stall, bus_read} !== want[c]) begin
        bad++; $display("FAIL b2b_cycle%0d: rv,stall,rd=%b want %b", c, {resp_valid, stall, bus_read}, want[c]);
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_timeout();
    obs_t o;
`ifdef LSU_TIMEOUT_EN
    run_txn(1'b0, 2'd2, 1'b0, 32'h700, 32'h0, 32'hCAFE_F00D, 40, o);
    total++;
    if (!o.resp_seen || o.nstrobe != TIMEOUT || o.err !== 1'b1 || o.rdata !== 32'h0) begin
      bad++; $display("FAIL timeout: seen=%0d strobes=%0d err=%b rdata=%h want 1 %0d 1 0",
                      o.resp_seen, o.nstrobe, o.err, o.rdata, TIMEOUT);
    end
`else
    run_txn(1'b0, 2'd2, 1'b0, 32'h700, 32'h0, 32'hCAFE_F00D, 1000, o);
    total++;
    if (!o.resp_seen || o.nstrobe != 1001 || !o.held || o.err !== 1'b0 || o.rdata !== 32'hCAFE_F00D) begin
      bad++; $display("FAIL no_timeout: seen=%0d strobes=%0d held=%0d err=%b rdata=%h want 1 1001 1 0 cafef00d",
                      o.resp_seen, o.nstrobe, o.held, o.err, o.rdata);
    end
`endif
  endtask

  task automatic test_random();
    obs_t        o;
    exp_t        e;
    logic [31:0] r, addr, wd, rd;
    logic [1:0]  sz;
    int          waits, want_strobes, want_cycle;
    for (int n = 0; n < 60; n++) begin
      r    = $urandom;
      sz   = r[1:0];
      addr = $urandom;
      if (r[4]) addr = addr & ~((32'd1 << sz) - 32'd1);
      wd    = $urandom;
      rd    = $urandom;
      waits = int'(r[6:5]);
      e     = model(r[7], sz, r[8], addr, wd, rd);
      run_txn(r[7], sz, r[8], addr, wd, rd, waits, o);
      want_strobes = e.legal ? waits + 1 : 0;
      want_cycle   = e.legal ? waits + 2 : 1;
      total++;
      if (!o.resp_seen || o.nstrobe != want_strobes || o.resp_cycle != want_cycle ||
          o.err !== !e.legal || !o.resp_clean || o.after_valid !== 1'b0) begin
        bad++; $display("FAIL rnd%0d_flow: strobes=%0d cycle=%0d err=%b clean=%0d after=%b want %0d %0d %b 1 0",
                        n, o.nstrobe, o.resp_cycle, o.err, o.resp_clean, o.after_valid,
                        want_strobes, want_cycle, !e.legal);
      end
      total++;
      if (e.legal && ({o.rd_s, o.wr_s, o.addr, o.be} !== {!r[7], r[7], e.baddr, e.be} ||
                      !o.held || !o.access_stall || (r[7] && o.wdata !== e.wdata))) begin
        bad++; $display("FAIL rnd%0d_bus: rd=%b wr=%b addr=%h be=%b wd=%h held=%0d want %b %b %h %b %h 1",
                        n, o.rd_s, o.wr_s, o.addr, o.be, o.wdata, o.held,
                        !r[7], r[7], e.baddr, e.be, e.wdata);
      end
      total++;
      if (o.rdata !== e.rdata || o.hold_rdata !== e.rdata) begin
        bad++; $display("FAIL rnd%0d_data: rdata=%h held=%h want %h (size=%0d addr=%h signed=%b)",
                        n, o.rdata, o.hold_rdata, e.rdata, sz, addr, r[8]);
      end
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_address = 32'h0; req_writedata = 32'h0; bus_waitrequest = 1'b0; bus_readdata = 32'h0;
    test_reset();
    test_word_store();
    test_byte_load();
    test_half();
    test_illegal();
    test_reset_mid_access();
    test_back_to_back();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_lsu_bus_bridge.md
Name: mips_lsu_bus_bridge

Overview:
Load/store unit between the CPU data port and a word-addressed data bus with wait states. Registers one CPU memory request, and generates the byte enables and lane-replicated write data for byte, half-word and word accesses. Holds the CPU stalled while the bus asserts waitrequest, then returns sign- or zero-extended load data. Sits directly downstream of the CPU datapath's data_address/data_writedata outputs and upstream of data memory.

Parameters:
TIMEOUT_CYCLES, 256, waitrequest cycles tolerated before abort; used only when LSU_TIMEOUT_EN is defined; must be >= 1.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  CPU requests a memory access this cycle.
req_write  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_address  in  32  byte address from the ALU.
req_writedata  in  32  store data; low byte or low half is used for narrow stores.
stall  out  1  CPU must hold its PC and request.
resp_valid  out  1  one-cycle pulse: the access is complete.
resp_readdata  out  32  extended load data; valid with resp_valid on loads, 0 otherwise.
resp_error  out  1  valid with resp_valid: misaligned, reserved size, or timeout.
bus_address  out  32  word address {addr[31:2],2'b00}.
bus_read  out  1  read strobe.
bus_write  out  1  write strobe.
bus_byteenable  out  4  lane k = bits [8k+7:8k] = byte offset k (little-endian lanes).
bus_writedata  out  32  lane-replicated store data.
bus_waitrequest  in  1  slave not ready; strobes and fields held.
bus_readdata  in  32  sampled in the cycle waitrequest is low.

Behaviour:
- States:
  - IDLE: accepts a request.
  - ACCESS: bus strobe active.
  - RESP: result presented.
- Reset (synchronous): state IDLE. All outputs 0 (stall, resp_valid, resp_readdata, resp_error, bus_*).
- IDLE with req_valid:
  - Register all req_* fields. Later changes on req_* are ignored until the next IDLE.
  - stall is high combinationally in this cycle.
  - Aligned and legal: go to ACCESS.
  - Illegal: go to RESP with resp_error=1 and no bus strobe. Illegal means size 11, half with addr[0]=1, or word with addr[1:0]!=0.
- ACCESS:
  - Assert bus_read or bus_write; bus_address, byteenable and writedata come from the registers. stall=1.
  - If bus_waitrequest=1, stay and hold everything.
  - If bus_waitrequest=0, capture bus_readdata (loads) and go to RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; stall=0; strobes low; then IDLE.
  - req_valid in RESP is not accepted. It is sampled again in IDLE on the following cycle.
- Minimum latency with zero wait states: request accepted at cycle 0, strobe in cycle 1, resp_valid in cycle 2. Each waitrequest cycle adds 1.
- Byte enables:
  - byte: 1<<addr[1:0].
  - half: 0011 if addr[1]=0, else 1100.
  - word: 1111.
- Write data:
  - byte: {4{wd[7:0]}}.
  - half: {2{wd[15:0]}}.
  - word: wd.
- Load extraction:
  - byte: lane addr[1:0].
  - half: lanes {1,0} or {3,2}.
  - Then extend per req_signed. Word loads ignore req_signed.
- resp_readdata holds its value outside RESP; it is cleared only by reset or a new store/error response (which drive 0).
- Reset asserted in ACCESS: strobes drop at that edge and no response is issued. The slave must tolerate an abandoned transfer.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - An 8..32-bit counter clears on entry to ACCESS and increments each cycle with waitrequest=1.
  - When the count reaches TIMEOUT_CYCLES, drop the strobe and go to RESP with resp_error=1, resp_readdata=0.
- Undefined: the counter is absent; ACCESS waits indefinitely and TIMEOUT_CYCLES is unused.

Decomposition:
- Package mips_lsu_pkg:
  - size typedef (SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD).
  - state enum (IDLE, ACCESS, RESP).
  - alignment-check and byteenable functions.
- Sub-module mips_lsu_lane_align: combinational byteenable, write replication and load extract/extend. The FSM stays in the top.

Test Plan:
1. Word store, addr 0x1004, wd 0xDEADBEEF, waitrequest low -> cycle 1: bus_write=1, bus_address=0x1004, be=1111, bus_writedata=0xDEADBEEF. Cycle 2: resp_valid=1, resp_error=0.
2. Signed byte load, addr 0x2003, bus_readdata 0x80112233, 3 waitrequest cycles -> strobe held 4 cycles, be=1000, resp_readdata=0xFFFFFF80 at cycle 5. Same load unsigned -> 0x00000080.
3. Unsigned half load, addr 0x2002, readdata 0xABCD1234 -> be=1100, resp_readdata=0x0000ABCD. Half store addr 0x10, wd 0x0000BEEF -> be=0011, bus_writedata=0xBEEFBEEF.
4. Misaligned word load, addr 0x3001 -> no bus strobe ever, resp_valid with resp_error=1 at cycle 1, resp_readdata=0. Size 11 gives the same response.
5. Reset pulsed in the 2nd ACCESS cycle of a load -> next cycle state IDLE, all outputs 0, no resp_valid. A fresh request then completes normally.
6. With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, waitrequest held high -> strobe drops after 4 wait cycles, resp_error=1. Without the macro, the strobe is still high after 1000 cycles.
